// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache with burst line refill.
// Define DCACHE_STATS_EN to add hit_count / miss_count outputs.
module dcache_direct_mapped #(
   parameter int NUM_LINES      = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] dcache_addr,
   input  logic        dcache_re,
   input  logic [3:0]  dcache_we,
   input  logic [31:0] dcache_din,
   output logic [31:0] dcache_dout,
   output logic        stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_rw,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_data,
   output logic [3:0]  mem_req_mask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   // state         | meaning
   // S_IDLE        | accepting requests, hits served with no stall
   // S_REFILL_REQ  | line read request held on memory port
   // S_REFILL_RESP | collecting refill beats into the latched line
   // S_WRITE_REQ   | write-through request held on memory port

   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int OFF_W   = $clog2(WORDS_PER_LINE);
   localparam int TAG_W   = 32 - INDEX_W - OFF_W - 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL_REQ,
      S_REFILL_RESP,
      S_WRITE_REQ
   } state_t;

   state_t state;

   logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0] valid;

   logic [OFF_W-1:0]   req_off;
   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [OFF_W-1:0]   lat_off;
   logic [INDEX_W-1:0] lat_idx;
   logic [TAG_W-1:0]   lat_tag;
   logic [OFF_W-1:0]   beat;

   logic        hit;
   logic        is_write;
   logic [31:0] cached_word;
   logic [31:0] merged_word;

   logic                     data_we;
   logic [INDEX_W+OFF_W-1:0] data_waddr;
   logic [31:0]              data_wdata;
   logic                     tag_we;
   logic                     unused_addr_bits;

   assign req_off  = dcache_addr[OFF_W+1:2];
   assign req_idx  = dcache_addr[OFF_W+2 +: INDEX_W];
   assign req_tag  = dcache_addr[31 -: TAG_W];
   assign unused_addr_bits = ^dcache_addr[1:0];

   assign cached_word = data_mem[{req_idx, req_off}];
   assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign is_write    = |dcache_we;
   assign stall       = (state != S_IDLE);

   always_comb begin
      merged_word = cached_word;
      for (int i = 0; i < 4; i++) begin
         if (dcache_we[i]) merged_word[8*i +: 8] = dcache_din[8*i +: 8];
      end
   end

   // Single write port: write hits in IDLE, refill beats in REFILL_RESP.
   always_comb begin
      data_we    = 1'b0;
      data_waddr = {req_idx, req_off};
      data_wdata = mem_resp_data;
      tag_we     = 1'b0;
      if (state == S_IDLE && is_write && hit) begin
         data_we    = 1'b1;
         data_wdata = merged_word;
      end else if (state == S_REFILL_RESP && mem_resp_valid) begin
         data_we    = 1'b1;
         data_waddr = {lat_idx, beat};
         tag_we     = &beat;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) data_mem[data_waddr] <= data_wdata;
      if (tag_we)  tag_mem[lat_idx]     <= lat_tag;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         valid         <= '0;
         dcache_dout   <= '0;
         beat          <= '0;
         lat_off       <= '0;
         lat_idx       <= '0;
         lat_tag       <= '0;
         mem_req_valid <= 1'b0;
         mem_req_rw    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_data  <= '0;
         mem_req_mask  <= '0;
`ifdef DCACHE_STATS_EN
         hit_count     <= '0;
         miss_count    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (is_write) begin
                  mem_req_valid <= 1'b1;
                  mem_req_rw    <= 1'b1;
                  mem_req_addr  <= {dcache_addr[31:2], 2'b00};
                  mem_req_data  <= dcache_din;
                  mem_req_mask  <= dcache_we;
                  state         <= S_WRITE_REQ;
`ifdef DCACHE_STATS_EN
                  if (hit) hit_count  <= hit_count + 32'd1;
                  else     miss_count <= miss_count + 32'd1;
`endif
               end else if (dcache_re) begin
                  if (hit) begin
                     dcache_dout <= cached_word;
`ifdef DCACHE_STATS_EN
                     hit_count   <= hit_count + 32'd1;
`endif
                  end else begin
                     lat_off       <= req_off;
                     lat_idx       <= req_idx;
                     lat_tag       <= req_tag;
                     mem_req_valid <= 1'b1;
                     mem_req_rw    <= 1'b0;
                     mem_req_addr  <= {dcache_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                     state         <= S_REFILL_REQ;
`ifdef DCACHE_STATS_EN
                     miss_count    <= miss_count + 32'd1;
`endif
                  end
               end
            end
            S_REFILL_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  beat          <= '0;
                  state         <= S_REFILL_RESP;
               end
            end
            S_REFILL_RESP: begin
               if (mem_resp_valid) begin
                  beat <= beat + 1'b1;
                  if (beat == lat_off) dcache_dout <= mem_resp_data;
                  if (&beat) begin
                     valid[lat_idx] <= 1'b1;
                     state          <= S_IDLE;
                  end
               end
            end
            S_WRITE_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Data-cache responder for the memory/writeback stage's dcache request interface: accepts word reads and byte-masked writes, returns read data, and raises stall on any access needing backing memory.
- Direct-mapped, write-through, no-write-allocate, multi-word lines, refilled by a single burst request on a valid/ready memory port.
- Returns full 32-bit words. Byte/half selection and sign extension stay in the requesting stage.

Parameters:
- NUM_LINES, 64, number of lines (power of 2); INDEX_W = log2(NUM_LINES)
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, >=2); OFF_W = log2(WORDS_PER_LINE)

Ports:
- clk  in  1  clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- dcache_addr  in  32  byte address; bits [1:0] ignored
- dcache_re  in  1  read request
- dcache_we  in  4  byte write mask; nonzero = write request
- dcache_din  in  32  write data
- dcache_dout  out  32  read data
- stall  out  1  high while cache busy; requester holds pipeline and request inputs
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  1 = write, 0 = line read
- mem_req_addr  out  32  byte address: line-aligned for reads, word-aligned for writes
- mem_req_data  out  32  write data
- mem_req_mask  out  4  write byte mask
- mem_resp_valid  in  1  one refill beat valid
- mem_resp_data  in  32  refill beat data, ascending word order from line base

Behaviour:
- Address split: offset = addr[OFF_W+1:2], index = next INDEX_W bits, tag = remaining upper bits.
- States: IDLE, REFILL_REQ, REFILL_RESP, WRITE_REQ.
- stall = (state != IDLE). Request inputs are sampled only in IDLE; ignored otherwise.
- Reset (async, any state): state IDLE, all valid bits 0, stall 0, mem_req_valid 0, dcache_dout 0, beat counter 0. Data/tag arrays not cleared.
- Read hit in IDLE (valid and tag match) at edge N: dcache_dout = word from edge N onward. No memory traffic, stall stays 0.
- Read miss at edge N:
  - Latch address; go to REFILL_REQ.
  - REFILL_REQ: mem_req_valid=1, rw=0, addr = line base. Hold until the ready handshake edge, then go to REFILL_RESP with beat counter 0.
  - REFILL_RESP: each mem_resp_valid edge writes data[index][beat] and increments the counter. The beat equal to the latched offset also loads dcache_dout.
  - Last beat (counter = WORDS_PER_LINE-1): set valid and tag, go to IDLE. stall falls in the following cycle with dcache_dout valid.
- dcache_dout holds its value until the next accepted read (hit, or miss completion).
- Write (dcache_we != 0) in IDLE at edge N:
  - If hit, merge din into the cached word per byte mask at edge N.
  - Miss: no allocate, no refill.
  - Always go to WRITE_REQ: mem_req_valid=1, rw=1, addr = {addr[31:2],2'b00}, data = din, mask = we. Held stable until the handshake edge, then IDLE.
- re and we both set: treated as a write; re ignored.
- mem_resp_valid outside REFILL_RESP: ignored. This covers stale beats after a reset.
- mem_req_* fields are don't-care when mem_req_valid=0 but must be stable while valid and not ready.
- Latencies:
  - Hit: 0 stall cycles.
  - Read miss: 1 + handshake wait + WORDS_PER_LINE beats.
  - Write: at least 1 stall cycle.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], reset to 0. Each accepted request (read or write) increments exactly one counter. Counters wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, read 0x100: stall rises next cycle; REFILL_REQ with addr 0x100, rw 0. Beats 0xAAAA0000..0xAAAA0003 -> dcache_dout 0xAAAA0000 when stall falls.
- Then read 0x108 -> no mem_req_valid, stall stays 0, dcache_dout 0xAAAA0002 after the edge.
- Write 0x104, din 0xDEADBEEF, we 4'b0011 -> mem write addr 0x104, mask 0011, held across 3 cycles of ready=0. Then read 0x104 hits -> 0xAAAABEEF.
- Write miss to 0x2000 -> exactly one write request, no refill. Next read 0x2000 -> miss with refill.
- Conflict: read 0x500 (same index as 0x100 at defaults) misses and evicts; read 0x100 then misses again.
- Assert reset_n low after 2 of 4 refill beats -> stall 0 and mem_req_valid 0 immediately. Extra beats ignored; read 0x100 misses.
